// File: rtl/cpu_controller.sv
// cpu_controller
//   Moore sequencer for the Simple RISC Machine: fetches one 16-bit
//   instruction per pass, decodes {opcode, op} and steps the datapath,
//   instruction register, PC and shared RAM port one micro-step per clock.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   opcode     in   IR[15:13]
//   op         in   IR[12:11]
//   nsel       out  one-hot register field select (001=Rn, 010=Rd, 100=Rm)
//   vsel       out  writeback select (0=C, 1=PC, 2=sximm8, 3=mdata)
//   write, loada, loadb, loadc, loads  out  datapath enables
//   asel, bsel out  A operand forced to 0 / B operand from sximm5
//   ALUop      out  ALU operation
//   load_ir, load_pc, reset_pc, load_addr  out  IR / PC / address reg enables
//   addr_sel   out  1 = RAM address from PC, 0 = from data-address register
//   mem_cmd    out  00 none, 01 read, 10 write
//   halted     out  high while in HALT
//   state_out  out  current state code (RST reads as 0)
module cpu_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] ALUop,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic [4:0] state_out
);

    // The execute step is split per instruction class so that ALUop, asel
    // and loads/loadc come from the state register alone and never from
    // the op field combinationally.
    typedef enum logic [4:0] {
        S_RST      = 5'd0,
        S_IF1,
        S_IF2,
        S_UPD_PC,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC_MOV,
        S_EXEC_MVN,
        S_EXEC_ADD,
        S_EXEC_AND,
        S_EXEC_CMP,
        S_WR_RD,
        S_ADDR,
        S_LD_ADDR,
        S_MRD1,
        S_MRD2,
        S_GET_RD,
        S_ST_EXEC,
        S_MWR,
        S_HALT
    } state_t;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_RST;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RST:    state_next = S_IF1;
            S_IF1:    state_next = S_IF2;
            S_IF2:    state_next = S_UPD_PC;
            S_UPD_PC: state_next = S_DECODE;
            S_DECODE: begin
                case ({opcode, op})
                    5'b110_10:                     state_next = S_WR_IMM;
                    5'b110_00, 5'b101_11:          state_next = S_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10,
                    5'b011_00, 5'b100_00:          state_next = S_GET_A;
                    default:                       state_next = S_HALT;
                endcase
            end
            S_WR_IMM: state_next = S_IF1;
            S_GET_A: begin
                // Only LDR/STR and the two-operand ALU ops reach GET_A.
                if (opcode == 3'b011 || opcode == 3'b100)
                    state_next = S_ADDR;
                else
                    state_next = S_GET_B;
            end
            S_GET_B: begin
                case ({opcode, op})
                    5'b110_00: state_next = S_EXEC_MOV;
                    5'b101_11: state_next = S_EXEC_MVN;
                    5'b101_01: state_next = S_EXEC_CMP;
                    5'b101_10: state_next = S_EXEC_AND;
                    default:   state_next = S_EXEC_ADD;
                endcase
            end
            S_EXEC_MOV,
            S_EXEC_MVN,
            S_EXEC_ADD,
            S_EXEC_AND: state_next = S_WR_RD;
            S_EXEC_CMP: state_next = S_IF1;
            S_WR_RD:    state_next = S_IF1;
            S_ADDR:     state_next = S_LD_ADDR;
            S_LD_ADDR:  state_next = (opcode == 3'b011) ? S_MRD1 : S_GET_RD;
            S_MRD1:     state_next = S_MRD2;
            S_MRD2:     state_next = S_IF1;
            S_GET_RD:   state_next = S_ST_EXEC;
            S_ST_EXEC:  state_next = S_MWR;
            S_MWR:      state_next = S_IF1;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_RST;
        endcase
    end

    always_comb begin
        nsel      = '0;
        vsel      = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        ALUop     = '0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = '0;
        halted    = 1'b0;
        case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = 2'b01;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = 2'b01;
                load_ir  = 1'b1;
            end
            S_UPD_PC: load_pc = 1'b1;
            S_WR_IMM: begin
                nsel  = NSEL_RN;
                vsel  = 2'd2;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC_MOV: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_EXEC_MVN: begin
                asel  = 1'b1;
                ALUop = 2'b11;
                loadc = 1'b1;
            end
            S_EXEC_ADD: loadc = 1'b1;
            S_EXEC_AND: begin
                ALUop = 2'b10;
                loadc = 1'b1;
            end
            S_EXEC_CMP: begin
                ALUop = 2'b01;
                loads = 1'b1;
            end
            S_WR_RD: begin
                nsel  = NSEL_RD;
                write = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_MRD1:    mem_cmd   = 2'b01;
            S_MRD2: begin
                mem_cmd = 2'b01;
                nsel    = NSEL_RD;
                vsel    = 2'd3;
                write   = 1'b1;
            end
            S_GET_RD: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_ST_EXEC: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MWR:  mem_cmd = 2'b10;
            S_HALT: halted  = 1'b1;
            default: ;
        endcase
    end

    assign state_out = state;

endmodule
